// File: rtl/hyperbus_resp_pkg.sv
// Shared types and constants for the HyperBus memory responder.
package hyperbus_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WR,
    ST_RD,
    ST_DONE
  } state_t;

  // Bit positions inside the 48-bit command/address word
  localparam int CA_RW = 47;  // 1 = read
  localparam int CA_AS = 46;  // 1 = register space
  localparam int CA_BT = 45;  // 1 = linear burst, 0 = wrapped

  // Register-space word addresses
  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;

  // RWDS drive patterns
  localparam logic [1:0] RWDS_CA = 2'b11;  // advertises fixed 2x latency
  localparam logic [1:0] RWDS_RD = 2'b10;  // one strobe toggle per word

endpackage

// File: rtl/hyperbus_mem_responder_if.sv
// Word-level HyperBus pin bundle between controller PHY and device.
interface hyperbus_mem_responder_if;
  logic        cs_ni;
  logic [15:0] dq_i;
  logic [1:0]  rwds_i;
  logic [15:0] dq_o;
  logic        dq_oe_o;
  logic [1:0]  rwds_o;
  logic        rwds_oe_o;

  modport master (
    output cs_ni, dq_i, rwds_i,
    input  dq_o, dq_oe_o, rwds_o, rwds_oe_o
  );

  modport slave (
    input  cs_ni, dq_i, rwds_i,
    output dq_o, dq_oe_o, rwds_o, rwds_oe_o
  );
endinterface

// File: rtl/hyperbus_resp_mem.sv
// Word array with per-byte write enables and an asynchronous read port.
module hyperbus_resp_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [WORDS];

  // Byte-granular write; be[1] covers the rising-edge byte [15:8]
  always_ff @(posedge clk) begin
    if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
    if (we && be[0]) mem[waddr][7:0]  <= wdata[7:0];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hyperbus_mem_responder.sv
// HyperRAM-like device end: CA capture, latency count, burst addressing,
// register space (ID0/CR0) and the backing word array.
module hyperbus_mem_responder
  import hyperbus_resp_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          LATENCY    = 6,
  parameter int          WRAP_WORDS = 16,
  parameter logic [15:0] ID0        = 16'h0C81,
  parameter logic [15:0] CR0_RESET  = 16'h8F1F
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  hyperbus_mem_responder_if.slave bus
);

  localparam int             AW        = $clog2(MEM_WORDS);
  localparam int             CW        = $clog2(2 * LATENCY) + 1;
  localparam logic [CW-1:0]  LAT_LAST  = CW'(2 * LATENCY - 1);
  localparam logic [AW-1:0]  WRAP_MASK = AW'(WRAP_WORDS - 1);

  if (LATENCY < 2) begin : g_bad_latency
    $error("hyperbus_mem_responder: LATENCY must be >= 2");
  end
  if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("hyperbus_mem_responder: MEM_WORDS must be a power of two");
  end
  if ((WRAP_WORDS & (WRAP_WORDS - 1)) != 0) begin : g_bad_wrap_words
    $error("hyperbus_mem_responder: WRAP_WORDS must be a power of two");
  end

  state_t         state, state_nxt;
  logic [CW-1:0]  cyc;
  logic [31:0]    ca_hi;
  logic [47:0]    ca_full;
  logic [31:0]    ca_word_addr;
  logic           is_read, is_reg, is_linear;
  logic           reg_cr0_hit;
  logic [15:0]    reg_rdata;
  logic [15:0]    cr0;
  logic [AW-1:0]  addr, addr_inc, addr_next;
  logic [15:0]    dq_q;
  logic [15:0]    mem_rdata;
  logic           mem_we;
  logic           dq_oe, rwds_oe;
  logic [1:0]     rwds_drv;
  logic           unused_ca;

  // The third CA word is consumed straight off the bus in cycle 2
  assign ca_full      = {ca_hi, bus.dq_i};
  assign ca_word_addr = {ca_full[44:16], ca_full[2:0]};
  assign unused_ca    = ^{ca_full[15:3], ca_word_addr};

  // Linear bursts roll over the whole array; wrapped bursts stay in their group
  assign addr_inc  = addr + AW'(1);
  assign addr_next = is_linear ? addr_inc : ((addr & ~WRAP_MASK) | (addr_inc & WRAP_MASK));

  assign mem_we = (state == ST_WR) && !is_reg && !bus.cs_ni;

  hyperbus_resp_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .be    (~bus.rwds_i),
    .waddr (addr),
    .wdata (bus.dq_i),
    .raddr (addr),
    .rdata (mem_rdata)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and pin drive; chip-select high overrides everything at once
  always_comb begin
    state_nxt = state;
    dq_oe     = 1'b0;
    rwds_oe   = 1'b0;
    rwds_drv  = 2'b00;
    case (state)
      ST_IDLE: state_nxt = ST_CA;
      ST_CA: begin
        rwds_oe  = 1'b1;
        rwds_drv = RWDS_CA;
        if (cyc == CW'(2))
          state_nxt = (!ca_full[CA_RW] && ca_full[CA_AS]) ? ST_WR : ST_LAT;
      end
      ST_LAT:  if (cyc == LAT_LAST) state_nxt = is_read ? ST_RD : ST_WR;
      ST_WR:   if (is_reg) state_nxt = ST_DONE;
      ST_RD: begin
        dq_oe    = 1'b1;
        rwds_oe  = 1'b1;
        rwds_drv = RWDS_RD;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    if (bus.cs_ni) begin
      state_nxt = ST_IDLE;
      dq_oe     = 1'b0;
      rwds_oe   = 1'b0;
    end
  end

  // CA capture, cycle count, burst address, register file and read prefetch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc         <= '0;
      ca_hi       <= '0;
      is_read     <= 1'b0;
      is_reg      <= 1'b0;
      is_linear   <= 1'b0;
      reg_cr0_hit <= 1'b0;
      reg_rdata   <= '0;
      cr0         <= CR0_RESET;
      addr        <= '0;
      dq_q        <= '0;
    end else if (!bus.cs_ni) begin
      case (state)
        ST_IDLE: begin
          ca_hi[31:16] <= bus.dq_i;
          cyc          <= CW'(1);
        end
        ST_CA: begin
          cyc <= cyc + CW'(1);
          if (cyc == CW'(1)) ca_hi[15:0] <= bus.dq_i;
          if (cyc == CW'(2)) begin
            is_read     <= ca_full[CA_RW];
            is_reg      <= ca_full[CA_AS];
            is_linear   <= ca_full[CA_BT];
            addr        <= ca_word_addr[AW-1:0];
            reg_cr0_hit <= (ca_word_addr == REG_CR0);
            if (ca_word_addr == REG_ID0)      reg_rdata <= ID0;
            else if (ca_word_addr == REG_CR0) reg_rdata <= cr0;
            else                              reg_rdata <= 16'h0000;
          end
        end
        ST_LAT: begin
          cyc <= cyc + CW'(1);
          if (cyc == LAT_LAST && is_read) begin
            dq_q <= is_reg ? reg_rdata : mem_rdata;
            addr <= addr_next;
          end
        end
        ST_RD: begin
          dq_q <= is_reg ? reg_rdata : mem_rdata;
          addr <= addr_next;
        end
        ST_WR: begin
          if (is_reg) begin
            if (reg_cr0_hit) cr0 <= bus.dq_i;
          end else begin
            addr <= addr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dq_o      = dq_q;
  assign bus.dq_oe_o   = dq_oe;
  assign bus.rwds_o    = rwds_drv;
  assign bus.rwds_oe_o = rwds_oe;

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Randomized bench for hyperbus_mem_responder against a word-array model.
module tb_hyperbus_mem_responder;

  localparam int          MEM_WORDS  = 1024;
  localparam int          LATENCY    = 6;
  localparam int          WRAP_WORDS = 16;
  localparam logic [15:0] ID0        = 16'h0C81;
  localparam logic [15:0] CR0_RESET  = 16'h8F1F;
  localparam int          FIRST      = 2 * LATENCY;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hyperbus_mem_responder_if bus();

  hyperbus_mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .LATENCY    (LATENCY),
    .WRAP_WORDS (WRAP_WORDS),
    .ID0        (ID0),
    .CR0_RESET  (CR0_RESET)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] ref_mem [MEM_WORDS];
  logic [15:0] ref_cr0;
  logic [15:0] wdat [MEM_WORDS];
  logic [1:0]  wmsk [MEM_WORDS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Array index of burst word k starting at word address base
  function automatic int word_at(input logic [31:0] base, input bit lin, input int k);
    longint unsigned b, grp, off;
    b = longint'(base);
    if (lin) return int'((b + longint'(k)) % MEM_WORDS);
    grp = b - (b % WRAP_WORDS);
    off = ((b % WRAP_WORDS) + longint'(k)) % WRAP_WORDS;
    return int'((grp + off) % MEM_WORDS);
  endfunction

  function automatic logic [15:0] reg_value(input logic [31:0] a);
    if (a == 32'h0)   return ID0;
    if (a == 32'h800) return ref_cr0;
    return 16'h0000;
  endfunction

  // One bus transaction; abort_at >= 0 raises cs_ni in that cycle and stops
  task automatic run_tx(input bit rd, input bit regsp, input bit lin, input logic [31:0] a,
                        input int n, input int abort_at, input string tag);
    logic [47:0] ca;
    logic [15:0] exp;
    int first, last_c, k, idx;
    bit ab, exp_rd, exp_rwoe;
    ca = {rd, regsp, lin, a[31:3], 13'($urandom), a[2:0]};
    first  = (!rd && regsp) ? 3 : FIRST;
    last_c = first + n - 1;
    if (abort_at >= 0 && abort_at < last_c) last_c = abort_at;
    for (int c = 0; c <= last_c; c++) begin
      ab = (c == abort_at);
      @(posedge clk); #1;
      bus.cs_ni  = ab;
      bus.dq_i   = 16'($urandom);
      bus.rwds_i = 2'($urandom);
      if (c < 3) bus.dq_i = ca[47-16*c -: 16];
      else if (!rd && c >= first) begin
        bus.dq_i   = wdat[c-first];
        bus.rwds_i = wmsk[c-first];
      end
      @(negedge clk);
      exp_rd   = !ab && rd && (c >= first);
      exp_rwoe = !ab && ((c == 1) || (c == 2) || exp_rd);
      check_eq({tag, ".dq_oe"}, 32'(bus.dq_oe_o), 32'(exp_rd));
      check_eq({tag, ".rwds_oe"}, 32'(bus.rwds_oe_o), 32'(exp_rwoe));
      if (exp_rwoe) check_eq({tag, ".rwds"}, 32'(bus.rwds_o), (c < 3) ? 32'h3 : 32'h2);
      if (exp_rd) begin
        k   = c - first;
        exp = regsp ? reg_value(a) : ref_mem[word_at(a, lin, k)];
        check_eq({tag, ".data"}, 32'(bus.dq_o), 32'(exp));
      end
      if (!rd && !ab && c >= first) begin
        k = c - first;
        if (regsp) begin
          if (k == 0 && a == 32'h800) ref_cr0 = wdat[0];
        end else begin
          idx = word_at(a, lin, k);
          if (!wmsk[k][1]) ref_mem[idx][15:8] = wdat[k][15:8];
          if (!wmsk[k][0]) ref_mem[idx][7:0]  = wdat[k][7:0];
        end
      end
    end
    @(posedge clk); #1;
    bus.cs_ni = 1'b1;
    bus.dq_i  = 16'($urandom);
    @(negedge clk);
    check_eq({tag, ".gap_dq_oe"}, 32'(bus.dq_oe_o), 32'h0);
    check_eq({tag, ".gap_rwds_oe"}, 32'(bus.rwds_oe_o), 32'h0);
  endtask

  initial begin
    int kind, n, ab, first;
    bit lin;
    logic [31:0] a;

    ref_cr0    = CR0_RESET;
    rst_n      = 1'b0;
    bus.cs_ni  = 1'b0;
    bus.dq_i   = 16'hA5A5;
    bus.rwds_i = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.dq_o", 32'(bus.dq_o), 32'h0);
    check_eq("rst.dq_oe", 32'(bus.dq_oe_o), 32'h0);
    check_eq("rst.rwds_o", 32'(bus.rwds_o), 32'h0);
    check_eq("rst.rwds_oe", 32'(bus.rwds_oe_o), 32'h0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.cs_ni = 1'b1;
    @(negedge clk);
    check_eq("idle.rwds_oe", 32'(bus.rwds_oe_o), 32'h0);

    for (int i = 0; i < MEM_WORDS; i++) begin
      wdat[i] = 16'($urandom);
      wmsk[i] = 2'b00;
    end
    run_tx(1'b0, 1'b0, 1'b1, 32'h0, MEM_WORDS, -1, "fill");

    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
    wmsk[0] = 2'b00;    wmsk[1] = 2'b10;    wmsk[2] = 2'b00;    wmsk[3] = 2'b00;
    run_tx(1'b0, 1'b0, 1'b1, 32'h10, 4, -1, "lin_wr");
    run_tx(1'b1, 1'b0, 1'b1, 32'h10, 4, -1, "lin_rd");
    run_tx(1'b1, 1'b0, 1'b0, 32'h1E, 4, -1, "wrap_rd");
    run_tx(1'b1, 1'b0, 1'b1, 32'(MEM_WORDS - 1), 2, -1, "top_rd");

    run_tx(1'b1, 1'b1, 1'b1, 32'h0,   1, -1, "reg_id0");
    run_tx(1'b1, 1'b1, 1'b1, 32'h800, 1, -1, "reg_cr0");
    wdat[0] = 16'h8F17;
    run_tx(1'b0, 1'b1, 1'b1, 32'h800, 3, -1, "reg_wr");
    run_tx(1'b1, 1'b1, 1'b1, 32'h800, 1, -1, "reg_cr0b");
    run_tx(1'b1, 1'b1, 1'b1, 32'h801, 1, -1, "reg_other");
    wdat[0] = 16'h1234;
    run_tx(1'b0, 1'b1, 1'b1, 32'h400, 1, -1, "reg_wr_drop");
    run_tx(1'b1, 1'b1, 1'b1, 32'h800, 1, -1, "reg_cr0c");

    for (int i = 0; i < 4; i++) begin
      wdat[i] = 16'($urandom);
      wmsk[i] = 2'b00;
    end
    run_tx(1'b0, 1'b0, 1'b1, 32'h40, 4, FIRST + 2, "abort_wr");
    run_tx(1'b1, 1'b0, 1'b1, 32'h40, 4, -1, "abort_rd");
    run_tx(1'b0, 1'b0, 1'b1, 32'h50, 4, 1, "ca_abort");
    run_tx(1'b1, 1'b0, 1'b1, 32'h50, 4, -1, "ca_abort_rd");

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 8);
      lin  = 1'($urandom);
      a    = $urandom;
      for (int i = 0; i < n; i++) begin
        wdat[i] = 16'($urandom);
        wmsk[i] = 2'($urandom);
      end
      if (kind >= 2) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h0;
          1:       a = 32'h800;
          default: a = $urandom;
        endcase
        if (kind == 2) n = 1;
      end
      first = (kind == 3) ? 3 : FIRST;
      ab    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, first + n - 1) : -1;
      case (kind)
        0:       run_tx(1'b0, 1'b0, lin, a, n, ab, "rnd_mem_wr");
        1:       run_tx(1'b1, 1'b0, lin, a, n, ab, "rnd_mem_rd");
        2:       run_tx(1'b1, 1'b1, lin, a, n, ab, "rnd_reg_rd");
        default: run_tx(1'b0, 1'b1, lin, a, n, ab, "rnd_reg_wr");
      endcase
      if (kind == 0) run_tx(1'b1, 1'b0, lin, a, n, -1, "rnd_mem_chk");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyperbus_mem_responder.md
# hyperbus_mem_responder

Synthesizable HyperBus memory responder (HyperRAM-like device end), word-level. It is the device side of the protocol that the hyperbus controller's PHY drives, and is used as an in-bench and FPGA-loopback target. Each clk_i cycle is one full CK period: the 16-bit bus carries the rising-edge byte in [15:8] and the falling-edge byte in [7:0]. An external DDR shim, not part of this block, converts to and from the 8-bit pins.

## Interface
- MEM_WORDS, 1024: 16-bit words in the array; power of two.
- LATENCY, 6: initial latency count; fixed 2x latency always applies; must be ≥2.
- WRAP_WORDS, 16: wrapped-burst group size in words; power of two.
- ID0, 16'h0C81: value returned from register address 0.
- CR0_RESET, 16'h8F1F: reset value of CR0.
- clk_i  in  1  clock; one CK period per cycle.
- rst_ni  in  1  asynchronous reset, active-low.
- cs_ni  in  1  chip select, active-low.
- dq_i  in  16  command/address and write data.
- rwds_i  in  2  write byte mask; [1] masks dq_i[15:8], [0] masks dq_i[7:0]; 1 = masked.
- dq_o  out  16  read data.
- dq_oe_o  out  1  dq output enable.
- rwds_o  out  2  rwds drive value.
- rwds_oe_o  out  1  rwds output enable.

## Operation
- States: IDLE, CA, LAT, WR, RD, DONE.
- IDLE -> CA on the first cycle cs_ni is sampled low; that cycle is cycle 0.
- CA words are taken in cycles 0, 1 and 2, MSW first, giving the 48-bit CA.
- CA field map:
  - CA[47]: 1 = read.
  - CA[46]: 1 = register space.
  - CA[45]: 1 = linear, 0 = wrapped.
  - CA[44:16]: upper address.
  - CA[2:0]: lower address.
  - Word address = {CA[44:16], CA[2:0]}.
- Memory space:
  - LAT until cycle 2*LATENCY-1, then WR or RD.
  - Data word k occupies cycle 2*LATENCY+k.
- Register write: zero latency. Data is taken in cycle 3 only, unmasked. State goes to DONE and further words are ignored.
- Register read: same latency as memory.
  - Address 0 returns ID0.
  - Address 0x800 returns CR0.
  - Any other address returns 16'h0000.
- Register write to 0x800 updates CR0; writes to other addresses are dropped. CR0 is storage only and does not change timing.
- Array index = address mod MEM_WORDS.
- Linear burst: +1 per word, wrapping at MEM_WORDS.
- Wrapped burst: low log2(WRAP_WORDS) bits increment modulo WRAP_WORDS; upper bits are held.
- Write: each unmasked byte is written. A fully masked word advances the address and writes nothing.
- Burst length is unbounded and ends only when cs_ni goes high.
- Output drive:
  - During CA: rwds_oe_o=1, rwds_o=2'b11 (signals 2x latency).
  - During RD: dq_oe_o=1, rwds_o=2'b10 (strobe toggles once per word), rwds_oe_o=1.
  - All other states: both enables are 0.
- cs_ni high in any state: both enables are gated low combinationally in the same cycle. State returns to IDLE on the next edge and any partial CA is discarded.
- Illegal CA (register-space read or write with LATENCY<2): not possible by parameter check. Elaboration fails if LATENCY<2.

## Timing
- Reset values:
  - State = IDLE.
  - dq_o = 0, rwds_o = 0, dq_oe_o = 0, rwds_oe_o = 0.
  - CR0 = CR0_RESET.
  - Array contents are not reset.
- Read data: the word for burst index k is present on dq_o throughout cycle 2*LATENCY+k. The array is prefetched one word ahead so this is a registered output.
- Write data: sampled at the clk_i edge ending cycle 2*LATENCY+k. It is visible to a read in the next transaction.
- cs_ni must be high for at least 1 cycle between transactions. A cs_ni low in the cycle directly after DONE/IDLE entry starts a new cycle 0.
- Mid-write deassert: words sampled before the cs_ni high cycle are committed. No word is written in the cs_ni high cycle.

## Structure
- Package hyperbus_resp_pkg holds:
  - state enum;
  - CA bit-position constants (RW, AS, BT);
  - register addresses REG_ID0=0 and REG_CR0=0x800.
- Sub-module hyperbus_resp_mem holds the MEM_WORDS x 16 array with a 2-bit byte enable, one write port and one read port.
- Everything else lives in the top FSM/datapath: CA shift register, latency counter and burst address generator.

## Test plan
- Reset: assert rst_ni low with cs_ni low -> all outputs 0 and state IDLE. After release, a transaction started with cs_ni high->low proceeds normally.
- Linear write/readback: write 4 words 0x1111, 0x2222, 0x3333, 0x4444 at word 0x10, with rwds_i=2'b10 on word 1. Read back 4 words -> 0x1111, old[15:8]:0x22, 0x3333, 0x4444. First read word appears at cycle 12 (LATENCY=6).
- Wrapped read at 0x1E, 4 words -> data order 0x1E, 0x1F, 0x10, 0x11. Linear read at MEM_WORDS-1 -> MEM_WORDS-1, 0.
- Registers:
  - Read address 0 -> 0x0C81.
  - Read 0x800 -> 0x8F1F.
  - Write 0x800 with 0x8F17 in cycle 3 (rwds_oe_o low during data, no latency), then read 0x800 -> 0x8F17.
- Abort: raise cs_ni during write word 2 of a 4-word burst -> words 0 and 1 written, words 2 and 3 unchanged. Enables drop in the same cycle, and the next read transaction matches.
- CA-phase abort: raise cs_ni in cycle 1 -> no write and no drive. The next full transaction is decoded correctly.
